// File: rtl/axioma_mul_unit.sv
// Iterative shift-add multiplier for the AVR MUL/MULS/MULSU/FMUL/FMULS/FMULSU family.
// Signed modes are built only when AXIOMA_MUL_SIGNED_EN is defined; otherwise they report op_err.
module axioma_mul_unit #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 flag_c_out,
    output logic                 flag_z_out,
    output logic                 op_err,
    output logic [1:0]           state_dbg
);

    localparam int PW = 2 * WIDTH;
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    // Handshake: start is accepted on a rising edge whenever the unit is not in CALC
    // (IDLE or DONE); done pulses for one cycle when result/flags/op_err are refreshed.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state, state_nxt;
    logic [2:0]                op_q;
    logic [PW-1:0]             a_q;
    logic [PW-1:0]             acc;
    logic [WIDTH-1:0]          b_q;
    logic [CW-1:0]             cnt;
    logic                      load;
    logic                      last;
    logic [BITS_PER_CYCLE-1:0] chunk;
    logic [PW-1:0]             a_ext;
    logic [PW-1:0]             pp;
    logic [PW-1:0]             r_fin;
    logic                      err;

    assign load      = start && (state != S_CALC);
    assign last      = (cnt == LAST_CNT);
    assign chunk     = b_q[BITS_PER_CYCLE-1:0];
    assign r_fin     = op_q[2] ? {acc[PW-2:0], 1'b0} : acc;
    assign state_dbg = state;

`ifdef AXIOMA_MUL_SIGNED_EN
    // A signed multiplier's top chunk carries negative weight: subtract 2^BPC * A when its MSB is set.
    always_comb begin
        a_ext = {{WIDTH{1'b0}}, operand_a};
        if (op[1:0] == 2'b01 || op[1:0] == 2'b10)
            a_ext = {{WIDTH{operand_a[WIDTH-1]}}, operand_a};
        pp = a_q * {{(PW-BITS_PER_CYCLE){1'b0}}, chunk};
        if (op_q[1:0] == 2'b01 && last && chunk[BITS_PER_CYCLE-1])
            pp = pp - (a_q << BITS_PER_CYCLE);
        err = (op_q[1:0] == 2'b11);
    end
`else
    always_comb begin
        a_ext = {{WIDTH{1'b0}}, operand_a};
        pp    = a_q * {{(PW-BITS_PER_CYCLE){1'b0}}, chunk};
        err   = (op_q[1:0] != 2'b00);
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CALC;
            S_CALC:  if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_CALC : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (load) begin
            op_q <= op;
            a_q  <= a_ext;
            b_q  <= operand_b;
            acc  <= '0;
            cnt  <= '0;
        end else if (state == S_CALC) begin
            acc  <= acc + pp;
            a_q  <= a_q << BITS_PER_CYCLE;
            b_q  <= b_q >> BITS_PER_CYCLE;
            cnt  <= cnt + CW'(1);
        end
    end

    // Outputs are refreshed on the edge that leaves DONE, so done follows edge E+N+1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            flag_c_out <= 1'b0;
            flag_z_out <= 1'b0;
            op_err     <= 1'b0;
        end else begin
            busy <= (state_nxt == S_CALC);
            done <= (state == S_DONE);
            if (state == S_DONE) begin
                if (err) begin
                    result     <= '0;
                    flag_c_out <= 1'b0;
                    flag_z_out <= 1'b1;
                    op_err     <= 1'b1;
                end else begin
                    result     <= r_fin;
                    flag_c_out <= acc[PW-1];
                    flag_z_out <= (r_fin == '0);
                    op_err     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_axioma_mul_unit.sv
// Directed bench for axioma_mul_unit (WIDTH=8, BITS_PER_CYCLE=4); expectations follow AXIOMA_MUL_SIGNED_EN.
module tb_axioma_mul_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  operand_a;
    logic [7:0]  operand_b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        flag_c_out;
    logic        flag_z_out;
    logic        op_err;
    logic [1:0]  state_dbg;

    int n_asserts = 0;
    int n_fail    = 0;
    int lat;
    int busy_cnt;
    int extra;

`ifdef AXIOMA_MUL_SIGNED_EN
    localparam bit SIGNED_ON = 1'b1;
`else
    localparam bit SIGNED_ON = 1'b0;
`endif

    axioma_mul_unit #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .flag_c_out (flag_c_out),
        .flag_z_out (flag_z_out),
        .op_err     (op_err),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Issues one op, then waits (bounded) for done; returns edges from E to done and busy cycles.
    task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         output int l, output int bc);
        @(posedge clk); #1;
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        operand_a = 8'($urandom_range(0, 255));
        operand_b = 8'($urandom_range(0, 255));
        l  = 0;
        bc = busy ? 1 : 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                l = k;
                break;
            end
            if (busy) bc++;
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] r, input logic c,
                           input logic z, input logic e);
        chk({tag, "_result"}, 32'(result), 32'(r));
        chk({tag, "_c"},      32'(flag_c_out), 32'(c));
        chk({tag, "_z"},      32'(flag_z_out), 32'(z));
        chk({tag, "_err"},    32'(op_err), 32'(e));
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 3'b000; operand_a = 8'h00; operand_b = 8'h00;
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // MUL FF*FF: latency and busy width
        do_op(3'b000, 8'hFF, 8'hFF, lat, busy_cnt);
        chk("mul_ff_latency", 32'(lat), 32'd3);
        chk("mul_ff_busy_cycles", 32'(busy_cnt), 32'd2);
        chk_out("mul_ff", 16'hFE01, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("held_result", 32'(result), 32'h0000FE01);

        do_op(3'b000, 8'h12, 8'h34, lat, busy_cnt);
        chk_out("mul_12_34", 16'h03A8, 1'b0, 1'b0, 1'b0);

        do_op(3'b001, 8'hFF, 8'h01, lat, busy_cnt);
        chk("muls_latency", 32'(lat), 32'd3);
        chk_out("muls", SIGNED_ON ? 16'hFFFF : 16'h0000, SIGNED_ON, !SIGNED_ON, !SIGNED_ON);

        do_op(3'b010, 8'hFF, 8'hFF, lat, busy_cnt);
        chk_out("mulsu", SIGNED_ON ? 16'hFF01 : 16'h0000, SIGNED_ON, !SIGNED_ON, !SIGNED_ON);

        do_op(3'b101, 8'h80, 8'h80, lat, busy_cnt);
        chk_out("fmuls", SIGNED_ON ? 16'h8000 : 16'h0000, 1'b0, !SIGNED_ON, !SIGNED_ON);

        do_op(3'b100, 8'hC0, 8'h80, lat, busy_cnt);
        chk_out("fmul_c0_80", 16'hC000, 1'b0, 1'b0, 1'b0);

        // carry taken before the fractional shift
        do_op(3'b100, 8'hFF, 8'hFF, lat, busy_cnt);
        chk_out("fmul_ff_ff", 16'hFC02, 1'b1, 1'b0, 1'b0);

        do_op(3'b000, 8'h00, 8'h37, lat, busy_cnt);
        chk_out("mul_zero", 16'h0000, 1'b0, 1'b1, 1'b0);

        do_op(3'b011, 8'h55, 8'h66, lat, busy_cnt);
        chk("reserved_latency", 32'(lat), 32'd3);
        chk_out("reserved", 16'h0000, 1'b0, 1'b1, 1'b1);

        // back-to-back: second start presented during DONE
        @(posedge clk); #1;
        start = 1'b1; op = 3'b000; operand_a = 8'h12; operand_b = 8'h34;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; op = 3'b100; operand_a = 8'hFF; operand_b = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_first_done", 32'(done), 32'd1);
        chk("b2b_first_result", 32'(result), 32'h000003A8);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("b2b_spacing", 32'(lat), 32'd3);
        chk_out("b2b_second", 16'hFC02, 1'b1, 1'b0, 1'b0);

        // start pulsed while busy is ignored
        @(posedge clk); #1;
        start = 1'b1; op = 3'b000; operand_a = 8'h0F; operand_b = 8'h0F;
        @(posedge clk); #1;
        op = 3'b000; operand_a = 8'hFF; operand_b = 8'hFF;
        chk("ignore_busy_high", 32'(busy), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int k = 2; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("ignore_latency", 32'(lat), 32'd3);
        chk_out("ignore", 16'h00E1, 1'b0, 1'b0, 1'b0);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk("ignore_no_extra_done", 32'(extra), 32'd0);

        // reset mid-CALC after a reserved op left Z=1 and op_err=1
        do_op(3'b011, 8'h01, 8'h01, lat, busy_cnt);
        chk("pre_reset_err", 32'(op_err), 32'd1);
        @(posedge clk); #1;
        start = 1'b1; op = 3'b000; operand_a = 8'hFF; operand_b = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk_out("mid_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk("post_rst_no_done", 32'(extra), 32'd0);
        chk("post_rst_state", 32'(state_dbg), 32'd0);

        do_op(3'b001, 8'hFF, 8'h01, lat, busy_cnt);
        chk("post_rst_latency", 32'(lat), 32'd3);
        chk_out("post_rst_muls", SIGNED_ON ? 16'hFFFF : 16'h0000, SIGNED_ON, !SIGNED_ON, !SIGNED_ON);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/axioma_mul_unit.md
# axioma_mul_unit

- Parametrised, multi-cycle multiply unit for the AxiomaCore-328 execute stage.
- Implements the AVR multiply family: MUL, MULS, MULSU, FMUL, FMULS and FMULSU.
- Works alongside the single-cycle ALU. It uses an iterative shift-add datapath that retires BITS_PER_CYCLE multiplier bits per clock, with a start/busy/done handshake.
- The default configuration matches the AVR 8-bit, 2-cycle multiply.

## Interface
- WIDTH, default 8: operand width in bits. The product is 2*WIDTH bits.
- BITS_PER_CYCLE, default 4: multiplier bits consumed per iteration. It must divide WIDTH. N = WIDTH/BITS_PER_CYCLE iterations.
- clk  in  1: system clock, rising-edge active. One clock domain only.
- reset_n  in  1: asynchronous, active-low reset.
- start  in  1: request an operation. Sampled only while busy=0.
- op  in  3: operation code.
  - op[2] = fractional.
  - op[1:0]: 00 unsigned×unsigned, 01 signed×signed, 10 signed A × unsigned B, 11 reserved.
- operand_a  in  WIDTH: multiplicand (Rd). Sampled with start.
- operand_b  in  WIDTH: multiplier (Rr). Sampled with start.
- busy  out  1: operation in progress.
- done  out  1: one-cycle pulse; result and flags are valid.
- result  out  2*WIDTH: product. Maps to R1:R0 when WIDTH=8.
- flag_c_out  out  1: carry flag.
- flag_z_out  out  1: zero flag.
- op_err  out  1: the accepted op was reserved or disabled. Valid with done.

## Operation
- FSM has three states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE → CALC when start=1.
  - Capture op, operand_a and operand_b into internal registers.
  - Clear the accumulator and the iteration counter.
- CALC: each cycle, add the partial product for the next BITS_PER_CYCLE multiplier bits and advance the counter.
  - After N cycles, go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
  - If start=1 while in DONE, take the IDLE→CALC actions directly (back-to-back operation, no bubble).
- busy=1 in CALC and 0 in IDLE and DONE. start is ignored while busy=1.
- Arithmetic: P is the exact mathematical product of the operands under the signedness given by op[1:0], taken modulo 2^(2*WIDTH).
  - Signed operands are two's complement.
- Result:
  - Integer ops: result = P.
  - Fractional ops: result = P << 1, zero-filled, truncated to 2*WIDTH bits.
- Flags:
  - flag_c_out = P[2*WIDTH-1], taken before the fractional shift.
  - flag_z_out = (result == 0), computed on the final shifted value.
- Reserved op[1:0]=11: the operation runs the normal N-cycle sequence.
  - At completion: result=0, flag_c_out=0, flag_z_out=1, op_err=1.
- Output holding: result, the flags and op_err change only on the DONE transition. They are held until the next completion.
- Reset:
  - On reset_n=0, all of busy, done, result, flag_c_out, flag_z_out and op_err go to 0 immediately, independent of clk.
  - The FSM returns to IDLE and any in-flight operation is discarded.
- Operand inputs may change freely after the start cycle.

## Timing
- Latency: start is sampled at rising edge E. done is high during the cycle following edge E+N+1.
  - Default configuration: N=2, so done follows edge E+3.
- busy rises after edge E and falls after edge E+N.
- Throughput: one operation per N+1 cycles when start is asserted again during DONE.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- AXIOMA_MUL_SIGNED_EN defined: signed modes 01 and 10 are supported, both integer and fractional.
- AXIOMA_MUL_SIGNED_EN undefined: op[1:0]=01 and 10 are handled exactly like the reserved code 11.
  - Full N+1 latency.
  - result=0, flag_c_out=0, flag_z_out=1, op_err=1.
  - No sign-handling logic is synthesised.
  - Unsigned MUL and FMUL are unaffected.

## Test plan
All cases use WIDTH=8 and BITS_PER_CYCLE=4.
- MUL (op=000), A=0xFF, B=0xFF → result=0xFE01, C=1, Z=0, op_err=0. done one cycle after the 3rd edge following start; busy high for exactly 2 cycles.
- MULS (op=001), A=0xFF, B=0x01 → result=0xFFFF, C=1. MULSU (op=010), A=0xFF, B=0xFF → result=0xFF01, C=1.
- FMULS (op=101), A=0x80, B=0x80 → result=0x8000, C=0, Z=0. FMUL (op=100), A=0xC0, B=0x80 → result=0xC000, C=0.
- MUL, A=0x00, B=0x37 → result=0x0000, Z=1, C=0. Then reserved op=011 → result=0, Z=1, op_err=1.
- Back-to-back and busy handling:
  - Start a new op during DONE → second done exactly 3 cycles after the first.
  - Pulse start with different operands while busy=1 → ignored; the first result is unchanged and no extra done.
- Reset:
  - Assert reset_n=0 mid-CALC → all outputs 0 immediately.
  - After release, no done pulse until a new start is accepted.
  - With AXIOMA_MUL_SIGNED_EN undefined, MULS 0xFF×0x01 → result=0, op_err=1.
